// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Reads a burst of `len` consecutive words from a RAM with a registered read
//   port and streams them out over a valid/ready interface through a 2-entry
//   FIFO. Addresses wrap modulo 2^ADDR_W.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             burst request (sampled only in IDLE, ignored if len==0)
//   start_addr, len   first address and word count (1..2^ADDR_W)
//   busy, done        burst in progress / one-cycle completion pulse
//   ram_addr          RAM read address
//   ram_rdata         RAM read data, valid the cycle after ram_addr
//   out_valid/ready   output handshake
//   out_data/last     output word and end-of-burst marker
module ram_burst_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;      // addresses issued so far
    logic                done_q, done_d;

    // One read can be in flight: address presented this cycle, data lands
    // on ram_rdata next cycle and is pushed into the FIFO on the edge after.
    logic                infl_q, infl_last_q;

    logic [1:0][DATA_W-1:0] mem_q;
    logic [1:0]             last_mem_q;
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             fifo_cnt_q;

    logic       pop, push, issue, last_issue;
    logic [2:0] occ;

    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_last  = out_valid && last_mem_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ram_addr  = addr_q;

    assign pop  = out_valid && out_ready;
    assign push = infl_q;

    // Slots already committed after this cycle's pop; pop implies a non-empty
    // FIFO so this never underflows.
    assign occ        = {1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue      = (state_q == READ) && (occ < 3'd2);
    assign last_issue = issue && ((cnt_q + LEN_ONE) == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = READ;
                    addr_d  = start_addr;
                    len_d   = len;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (issue) begin
                    cnt_d = cnt_q + LEN_ONE;
                    // After the final address ram_addr keeps that address.
                    if (last_issue) state_d = DRAIN;
                    else            addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            infl_q      <= issue;
            infl_last_q <= last_issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '0;
            last_mem_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]      <= ram_rdata;
                last_mem_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;
    localparam int AW = 5;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, out_valid, out_last;
    logic          out_ready = 1'b1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] out_data;

    ram_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .len(len), .busy(busy), .done(done), .ram_addr(ram_addr),
        .ram_rdata(ram_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // RAM model with registered read port, RAM[i] = i & 0xF
    logic [DW-1:0] ram [32];
    initial for (int i = 0; i < 32; i++) ram[i] = DW'(i & 15);
    always @(posedge clk) ram_rdata <= ram[ram_addr];

    int checks = 0, errors = 0;
    int pops = 0, done_seen = 0, done_exp = 0;
    logic [DW:0] exp_q[$];   // {last, data}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // out_ready: mode 0 = always 1, mode 1 = pattern 1,0,0 repeating
    int rdy_mode = 0;
    int rdy_ph = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else begin
            out_ready = (rdy_ph == 0);
            rdy_ph    = (rdy_ph + 1) % 3;
        end
    end

    // Monitor / scoreboard
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic [DW:0]   e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev && out_valid) chk("stall_hold", out_data, stall_data);
            chk("fifo_bound", dut.fifo_cnt_q <= 2'd2, 1);
            if (done) begin
                done_seen++;
                chk("busy_with_done", busy, 0);
            end
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word got %0h want none at %0t", {out_last, out_data}, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {out_last, out_data}, e);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_w(input logic [DW-1:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic do_start(input int a, input int n);
        @(negedge clk);
        start_addr = AW'(a);
        len        = (AW+1)'(n);
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        chk(name, k < 200, 1);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", ram_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // burst addr 3 len 4, full throughput, exact timing
        push_w(4'h3, 0); push_w(4'h4, 0); push_w(4'h5, 0); push_w(4'h6, 1);
        done_exp++;
        do_start(3, 4);
        @(negedge clk); chk("lat_c0", out_valid, 0);
        chk("busy_after_start", busy, 1);
        @(negedge clk); chk("lat_c1", out_valid, 0);
        @(negedge clk); chk("first_valid_c2", out_valid, 1);
        repeat (3) begin @(negedge clk); chk("stream_valid", out_valid, 1); end
        chk("last_on_6", out_last, 1);
        @(negedge clk); #1 chk("done_after_last", done, 1);
        chk("idle_ram_addr_hold", ram_addr, 6);

        // address wrap 30,31,0,1
        push_w(4'hE, 0); push_w(4'hF, 0); push_w(4'h0, 0); push_w(4'h1, 1);
        done_exp++;
        do_start(30, 4);
        wait_done("wrap_done");

        // backpressure, len 8 from 12
        push_w(4'hC, 0); push_w(4'hD, 0); push_w(4'hE, 0); push_w(4'hF, 0);
        push_w(4'h0, 0); push_w(4'h1, 0); push_w(4'h2, 0); push_w(4'h3, 1);
        done_exp++;
        rdy_ph   = 0;
        rdy_mode = 1;
        do_start(12, 8);
        wait_done("stall_done");
        @(negedge clk);
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // len==0 ignored
        do_start(5, 0);
        repeat (4) begin @(negedge clk); chk("len0_busy", busy, 0); chk("len0_valid", out_valid, 0); end

        // start during busy ignored
        push_w(4'h4, 0); push_w(4'h5, 0); push_w(4'h6, 0); push_w(4'h7, 1);
        done_exp++;
        do_start(20, 4);
        do_start(0, 5);
        wait_done("busy_start_done");
        repeat (6) begin @(negedge clk); chk("no_restart", busy, 0); end

        // reset mid-burst after 2 of 6 words
        push_w(4'hA, 0); push_w(4'hB, 0); push_w(4'hC, 0);
        push_w(4'hD, 0); push_w(4'hE, 0); push_w(4'hF, 1);
        begin
            int p0, k;
            p0 = pops;
            do_start(10, 6);
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                #1;
                if (pops >= p0 + 2) break;
            end
            chk("two_words_seen", k < 50, 1);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", ram_addr, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_w(4'h0, 1);
        done_exp++;
        do_start(0, 1);
        wait_done("post_rst_done");
        repeat (4) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_seen, done_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
